// File: rtl/jesd204b_tpl_pkg.sv
// rtl/jesd204b_tpl_pkg.sv - shared JESD204B transport-layer widths, offsets and state type
package jesd204b_tpl_pkg;

    // Receive FSM: IDLE until the first valid frame, STREAM while frames keep arriving
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } tpl_state_e;

    // Padding words needed so every lane carries the same number of words
    function automatic int calc_pad(input int lanes, input int convs);
        return ((convs % lanes) != 0) ? (lanes - (convs % lanes)) : 0;
    endfunction

    // Frame width in bits: one 16-bit word per converter plus padding words
    function automatic int calc_dw(input int lanes, input int convs);
        return 16 * (convs + calc_pad(lanes, convs));
    endfunction

    // Octets carried by each lane per frame
    function automatic int calc_octets(input int lanes, input int convs);
        return calc_dw(lanes, convs) / (8 * lanes);
    endfunction

    // Tail bits left over in each sample word
    function automatic int calc_tails(input int sample_size, input int res, input int ctrl);
        return sample_size - res - ctrl;
    endfunction

    // Bit offset of word 'word' in lane 'lane'; word 0 sits in the most significant octets
    function automatic int word_offset(input int octets, input int lane, input int word);
        return lane * 8 * octets + (octets - 2 - 2 * word) * 8;
    endfunction

endpackage

// File: rtl/jesd204b_tpl_rx_unpack.sv
// rtl/jesd204b_tpl_rx_unpack.sv - decode one 16-bit transport word into sample, control and tail check
module jesd204b_tpl_rx_unpack #(
    parameter  int RESOLUTION = 11,
    parameter  int CONTROL    = 2,
    parameter  int TAILS      = 3,
    localparam int CW         = (CONTROL > 0) ? CONTROL : 1
) (
    input  logic [15:0]           word_i,
    output logic [RESOLUTION-1:0] sample_o,
    output logic [CW-1:0]         ctrl_o,
    output logic                  tail_nz_o
);

    // Sample is MSB-aligned: the upper octet followed by the top RESOLUTION-8 bits of the lower octet
    assign sample_o = word_i[15 -: RESOLUTION];

    if (CONTROL > 0) begin : g_ctrl
        assign ctrl_o = word_i[CONTROL+TAILS-1 -: CW];
    end else begin : g_no_ctrl
        assign ctrl_o = '0;
    end

    if (TAILS > 0) begin : g_tail
        assign tail_nz_o = |word_i[TAILS-1:0];
    end else begin : g_no_tail
        assign tail_nz_o = 1'b0;
    end

endmodule

// File: rtl/jesd204b_tpl_rx.sv
// rtl/jesd204b_tpl_rx.sv - JESD204B receive transport layer: frame de-mapping, error checks and statistics
module jesd204b_tpl_rx
    import jesd204b_tpl_pkg::*;
#(
    parameter  int LANES       = 4,
    parameter  int CONVERTERS  = 4,
    parameter  int RESOLUTION  = 11,
    parameter  int CONTROL     = 2,
    parameter  int SAMPLE_SIZE = 16,
    localparam int DW          = calc_dw(LANES, CONVERTERS),
    localparam int CW          = (CONTROL > 0) ? CONTROL : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic [DW-1:0]                    rx_datain,
    input  logic                             err_clr,
    output logic [CONVERTERS*RESOLUTION-1:0] rx_dataout,
    output logic [CONVERTERS*CW-1:0]         rx_ctrl,
    output logic                             rx_valid,
    output logic                             tail_err,
    output logic                             pad_err,
    output logic                             err_sticky,
    output logic [15:0]                      frame_cnt,
    output logic [7:0]                       err_cnt
);

    localparam int PAD    = calc_pad(LANES, CONVERTERS);
    localparam int OCTETS = calc_octets(LANES, CONVERTERS);
    localparam int WPL    = OCTETS / 2;
    localparam int NWORDS = CONVERTERS + PAD;
    localparam int TAILS  = calc_tails(SAMPLE_SIZE, RESOLUTION, CONTROL);

    logic [CONVERTERS*RESOLUTION-1:0] sample_w;
    logic [CONVERTERS*CW-1:0]         ctrl_w;
    logic [CONVERTERS-1:0]            tail_nz_w;
    logic [NWORDS-1:0]                pad_nz_w;
    logic                             tail_any_w;
    logic                             pad_any_w;
    logic                             frame_err_w;

    tpl_state_e state_q, state_d;

    logic [CONVERTERS*RESOLUTION-1:0] data_q;
    logic [CONVERTERS*CW-1:0]         ctrl_q;
    logic                             tail_err_q;
    logic                             pad_err_q;
    logic                             err_sticky_q, err_sticky_d;
    logic [15:0]                      frame_cnt_q, frame_cnt_d;
    logic [7:0]                       err_cnt_q, err_cnt_d;

    // Word k lives in lane k/WPL at position k%WPL; words past the last converter are padding
    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        localparam int OFS = word_offset(OCTETS, k / WPL, k % WPL);
        if (k < CONVERTERS) begin : g_conv
            jesd204b_tpl_rx_unpack #(
                .RESOLUTION (RESOLUTION),
                .CONTROL    (CONTROL),
                .TAILS      (TAILS)
            ) u_unpack (
                .word_i    (rx_datain[OFS +: 16]),
                .sample_o  (sample_w[k*RESOLUTION +: RESOLUTION]),
                .ctrl_o    (ctrl_w[k*CW +: CW]),
                .tail_nz_o (tail_nz_w[k])
            );
            assign pad_nz_w[k] = 1'b0;
        end else begin : g_pad
            assign pad_nz_w[k] = |rx_datain[OFS +: 16];
        end
    end

    assign tail_any_w  = |tail_nz_w;
    assign pad_any_w   = |pad_nz_w;
    assign frame_err_w = en & (tail_any_w | pad_any_w);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stream while en is held, fall back to idle on the first gap
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (en)  state_d = ST_STREAM;
            ST_STREAM: if (!en) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Capture decoded frame and its error flags on valid beats; hold them across gaps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            ctrl_q     <= '0;
            tail_err_q <= 1'b0;
            pad_err_q  <= 1'b0;
        end else if (en) begin
            data_q     <= sample_w;
            ctrl_q     <= ctrl_w;
            tail_err_q <= tail_any_w;
            pad_err_q  <= pad_any_w;
        end
    end

    // Statistics next state: saturating counters; a fresh error overrides a simultaneous clear
    always_comb begin
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (en && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (err_clr) begin
            err_cnt_d    = {7'd0, frame_err_w};
            err_sticky_d = frame_err_w;
        end else if (frame_err_w) begin
            err_sticky_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt_q  <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign rx_dataout = data_q;
    assign rx_ctrl    = ctrl_q;
    assign rx_valid   = (state_q == ST_STREAM);
    assign tail_err   = tail_err_q;
    assign pad_err    = pad_err_q;
    assign err_sticky = err_sticky_q;
    assign frame_cnt  = frame_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_jesd204b_tpl_rx.sv
// tb/tb_jesd204b_tpl_rx.sv - scoreboard bench for jesd204b_tpl_rx with C=4 and C=3 (padded) instances
module tb_jesd204b_tpl_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        err_clr;
    logic [63:0] rx_datain;

    logic [43:0] d0_data;
    logic [7:0]  d0_ctrl;
    logic        d0_valid, d0_tail, d0_pad, d0_st;
    logic [15:0] d0_fc;
    logic [7:0]  d0_ec;

    logic [32:0] d1_data;
    logic [5:0]  d1_ctrl;
    logic        d1_valid, d1_tail, d1_pad, d1_st;
    logic [15:0] d1_fc;
    logic [7:0]  d1_ec;

    typedef struct packed {
        logic        valid;
        logic [43:0] data0;
        logic [7:0]  ctrl0;
        logic        tail0, pad0, st0;
        logic [15:0] fc0;
        logic [7:0]  ec0;
        logic [32:0] data1;
        logic [5:0]  ctrl1;
        logic        tail1, pad1, st1;
        logic [15:0] fc1;
        logic [7:0]  ec1;
    } exp_t;

    exp_t sb_q[$];

    int n_chk = 0;
    int n_err = 0;

    logic        m_valid;
    logic [43:0] m_data [2];
    logic [7:0]  m_ctrl [2];
    logic        m_tail [2];
    logic        m_pad  [2];
    logic        m_st   [2];
    logic [15:0] m_fc   [2];
    logic [7:0]  m_ec   [2];
    int          nconv  [2];

    always #5 clk = ~clk;

    jesd204b_tpl_rx #(
        .LANES(4), .CONVERTERS(4), .RESOLUTION(11), .CONTROL(2), .SAMPLE_SIZE(16)
    ) u_dut (
        .clk(clk), .reset(reset), .en(en), .rx_datain(rx_datain), .err_clr(err_clr),
        .rx_dataout(d0_data), .rx_ctrl(d0_ctrl), .rx_valid(d0_valid),
        .tail_err(d0_tail), .pad_err(d0_pad), .err_sticky(d0_st),
        .frame_cnt(d0_fc), .err_cnt(d0_ec)
    );

    jesd204b_tpl_rx #(
        .LANES(4), .CONVERTERS(3), .RESOLUTION(11), .CONTROL(2), .SAMPLE_SIZE(16)
    ) u_dut_c3 (
        .clk(clk), .reset(reset), .en(en), .rx_datain(rx_datain), .err_clr(err_clr),
        .rx_dataout(d1_data), .rx_ctrl(d1_ctrl), .rx_valid(d1_valid),
        .tail_err(d1_tail), .pad_err(d1_pad), .err_sticky(d1_st),
        .frame_cnt(d1_fc), .err_cnt(d1_ec)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        nconv[0] = 4;
        nconv[1] = 3;
        for (int u = 0; u < 2; u++) begin
            m_data[u] = '0; m_ctrl[u] = '0; m_tail[u] = 1'b0; m_pad[u] = 1'b0;
            m_st[u] = 1'b0; m_fc[u] = '0; m_ec[u] = '0;
        end
    endtask

    // Reference: with L=4 and DW=64 each lane holds one word, converter k at bits [16k+15:16k]
    task automatic model_step(input logic [63:0] d, input logic e, input logic c);
        logic [15:0] w;
        logic        err;
        m_valid = e;
        for (int u = 0; u < 2; u++) begin
            err = 1'b0;
            if (e) begin
                m_tail[u] = 1'b0;
                m_pad[u]  = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    w = d[k*16 +: 16];
                    if (k < nconv[u]) begin
                        m_data[u][k*11 +: 11] = {w[15:8], w[7:5]};
                        m_ctrl[u][k*2 +: 2]   = w[4:3];
                        if (w[2:0] != 3'd0) m_tail[u] = 1'b1;
                    end else if (w != 16'd0) begin
                        m_pad[u] = 1'b1;
                    end
                end
                err = m_tail[u] | m_pad[u];
                if (m_fc[u] != 16'hFFFF) m_fc[u] = m_fc[u] + 16'd1;
            end
            if (c) begin
                m_ec[u] = err ? 8'd1 : 8'd0;
                m_st[u] = err;
            end else if (err) begin
                m_st[u] = 1'b1;
                if (m_ec[u] != 8'hFF) m_ec[u] = m_ec[u] + 8'd1;
            end
        end
    endtask

    task automatic push_exp();
        exp_t x;
        x.valid = m_valid;
        x.data0 = m_data[0];        x.ctrl0 = m_ctrl[0];
        x.tail0 = m_tail[0];        x.pad0  = m_pad[0];  x.st0 = m_st[0];
        x.fc0   = m_fc[0];          x.ec0   = m_ec[0];
        x.data1 = m_data[1][32:0];  x.ctrl1 = m_ctrl[1][5:0];
        x.tail1 = m_tail[1];        x.pad1  = m_pad[1];  x.st1 = m_st[1];
        x.fc1   = m_fc[1];          x.ec1   = m_ec[1];
        sb_q.push_back(x);
    endtask

    task automatic compare_outputs();
        exp_t x;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        x = sb_q.pop_front();
        chk("c4_valid", d0_valid, x.valid);
        chk("c4_data",  d0_data,  x.data0);
        chk("c4_ctrl",  d0_ctrl,  x.ctrl0);
        chk("c4_tail",  d0_tail,  x.tail0);
        chk("c4_pad",   d0_pad,   x.pad0);
        chk("c4_stky",  d0_st,    x.st0);
        chk("c4_fcnt",  d0_fc,    x.fc0);
        chk("c4_ecnt",  d0_ec,    x.ec0);
        chk("c3_valid", d1_valid, x.valid);
        chk("c3_data",  d1_data,  x.data1);
        chk("c3_ctrl",  d1_ctrl,  x.ctrl1);
        chk("c3_tail",  d1_tail,  x.tail1);
        chk("c3_pad",   d1_pad,   x.pad1);
        chk("c3_stky",  d1_st,    x.st1);
        chk("c3_fcnt",  d1_fc,    x.fc1);
        chk("c3_ecnt",  d1_ec,    x.ec1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_c4_valid"}, d0_valid, 64'd0);
        chk({tag, "_c4_data"},  d0_data,  64'd0);
        chk({tag, "_c4_ctrl"},  d0_ctrl,  64'd0);
        chk({tag, "_c4_flags"}, {d0_tail, d0_pad, d0_st}, 64'd0);
        chk({tag, "_c4_cnts"},  {d0_fc, d0_ec}, 64'd0);
        chk({tag, "_c3_valid"}, d1_valid, 64'd0);
        chk({tag, "_c3_data"},  d1_data,  64'd0);
        chk({tag, "_c3_flags"}, {d1_tail, d1_pad, d1_st}, 64'd0);
        chk({tag, "_c3_cnts"},  {d1_fc, d1_ec}, 64'd0);
    endtask

    // One clock: drive at negedge, predict, then compare 1 ns after the rising edge
    task automatic run(input logic [63:0] d, input logic e, input logic c);
        @(negedge clk);
        rx_datain = d;
        en        = e;
        err_clr   = c;
        model_step(d, e, c);
        push_exp();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; err_clr = 1'b0; rx_datain = '0;
        model_reset();
        #1 reset = 1'b0;
        #1 check_zero("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run(64'h0000_0000_0000_B460, 1'b1, 1'b0);
        run(64'h0000_0000_0000_B478, 1'b1, 1'b0);
        run(64'h0000_0000_0000_B461, 1'b1, 1'b0);
        run(64'h0000_0000_0000_B460, 1'b1, 1'b0);
        run(64'h0001_0000_0000_B460, 1'b1, 1'b0);
        run(64'h0000_0000_0000_B460, 1'b1, 1'b0);
        run(64'h8000_0000_0000_0000, 1'b1, 1'b0);
        run(64'h0000_0000_0000_B460, 1'b0, 1'b0);
        run(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        run(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run({$urandom, $urandom}, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        run(64'h0000_0000_0000_B460, 1'b1, 1'b1);
        for (int i = 0; i < 260; i++) begin
            run(64'h0000_0000_0000_0001, 1'b1, 1'b0);
        end
        run(64'h0000_0000_0000_0001, 1'b1, 1'b1);
        run(64'h0000_0000_0000_0000, 1'b0, 1'b1);
        run(64'h0000_0000_0000_0001, 1'b1, 1'b0);

        run(64'h0000_0000_0000_B478, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        sb_q.delete();
        @(negedge clk);
        en = 1'b1;
        rx_datain = 64'h0000_0000_0000_B461;
        @(posedge clk);
        #1 check_zero("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;

        run(64'h0000_0000_0000_B478, 1'b1, 1'b0);
        run(64'h0000_0001_0000_0000, 1'b1, 1'b0);
        run(64'h0000_0000_0000_0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
